// File: rtl/axis_header_insert_multi.sv
// Purpose : prepends a 0..HDR_BYTES_MAX byte header to each AXI-Stream packet, repacking bytes into full beats.
// Latency : 1 cycle from a header or payload handshake to valid_out; no bubbles while ready_out=1.
// Backpr. : single output register holds its beat while valid_out & !ready_out; ready_in/ready_insert follow it.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   valid_in/data_in/keep_in/last_in payload stream in (byte 0 = MSB byte), ready_in back
//   valid_out/data_out/keep_out/last_out repacked stream out, ready_out from the sink
//   valid_insert/header_insert/header_len header side channel (right-aligned bytes), ready_insert back
module axis_header_insert_multi #(
    parameter int DATA_WD       = 32,
    parameter int DATA_BYTE_WD  = DATA_WD / 8,
    parameter int HDR_BYTES_MAX = 8,
    parameter int HDR_WD        = HDR_BYTES_MAX * 8,
    parameter int LEN_WD        = $clog2(HDR_BYTES_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,

    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,

    input  logic                    valid_insert,
    input  logic [HDR_WD-1:0]       header_insert,
    input  logic [LEN_WD-1:0]       header_len,
    output logic                    ready_insert
);

    // Header shift register is padded by two beats so the "next beat" slice
    // is always in range, whatever the header/data width ratio.
    localparam int SH_WD  = HDR_WD + 2 * DATA_WD;
    localparam int CNT_WD = $clog2(DATA_BYTE_WD + 1);

    typedef enum logic [1:0] {IDLE, HDR, BODY, TAIL} state_t;

    state_t                  state;
    logic                    rst_q;
    logic [SH_WD-1:0]        hdr_sh;     // remaining header bytes, MSB-aligned
    logic [LEN_WD-1:0]       hdr_cnt;    // full header beats still to emit
    logic [CNT_WD-1:0]       r_cnt;      // residual bytes carried between payload beats
    logic [CNT_WD-1:0]       tail_cnt;   // bytes held for the extra tail beat
    logic [DATA_WD-1:0]      res_dat;    // residual bytes, MSB-aligned, zero below

    logic                    can_load;
    logic                    active;
    logic                    hdr_hs;
    logic                    in_hs;
    logic [SH_WD-1:0]        hdr_in_sh;
    logic [LEN_WD-1:0]       nh_in;
    logic [CNT_WD-1:0]       r_in;
    logic [DATA_WD-1:0]      din_m;
    logic [2*DATA_WD-1:0]    cat;
    int                      fill;

    function automatic logic [DATA_BYTE_WD-1:0] keep_top(input int c);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            k[DATA_BYTE_WD-1-i] = (i < c);
        end
        return k;
    endfunction

    always_comb begin
        can_load     = !valid_out || ready_out;
        // Handshakes stay closed during reset and for one cycle after it.
        active       = !rst && !rst_q;
        ready_insert = active && (state == IDLE);
        ready_in     = active && (state == BODY) && can_load;
        hdr_hs       = valid_insert && ready_insert;
        in_hs        = valid_in && ready_in;

        // Left-align the used header bytes so beats are taken from the top.
        hdr_in_sh = {header_insert, {(2*DATA_WD){1'b0}}}
                    << ((HDR_BYTES_MAX - int'(header_len)) * 8);
        nh_in     = LEN_WD'(int'(header_len) / DATA_BYTE_WD);
        r_in      = CNT_WD'(int'(header_len) % DATA_BYTE_WD);

        // Zero disabled payload bytes so they never leak into data_out.
        din_m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            din_m[i*8 +: 8] = keep_in[i] ? data_in[i*8 +: 8] : 8'h00;
        end

        // Upper half: outgoing beat; lower half: new residual.
        cat  = {res_dat, {DATA_WD{1'b0}}} | ({din_m, {DATA_WD{1'b0}}} >> (int'(r_cnt) * 8));
        fill = int'(r_cnt) + $countones(keep_in);
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state     <= IDLE;
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
            hdr_sh    <= '0;
            hdr_cnt   <= '0;
            r_cnt     <= '0;
            tail_cnt  <= '0;
            res_dat   <= '0;
        end else begin
            if (can_load) begin
                valid_out <= 1'b0;
                data_out  <= '0;
                keep_out  <= '0;
                last_out  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hdr_hs) begin
                        r_cnt <= r_in;
                        if ((nh_in != '0) && can_load) begin
                            // First header beat goes out straight away to keep 1-cycle latency.
                            valid_out <= 1'b1;
                            data_out  <= hdr_in_sh[SH_WD-1 -: DATA_WD];
                            keep_out  <= '1;
                            last_out  <= 1'b0;
                            hdr_sh    <= hdr_in_sh << DATA_WD;
                            res_dat   <= hdr_in_sh[SH_WD-DATA_WD-1 -: DATA_WD];
                            hdr_cnt   <= nh_in - LEN_WD'(1);
                            state     <= (nh_in == LEN_WD'(1)) ? BODY : HDR;
                        end else begin
                            hdr_sh    <= hdr_in_sh;
                            res_dat   <= hdr_in_sh[SH_WD-1 -: DATA_WD];
                            hdr_cnt   <= nh_in;
                            state     <= (nh_in != '0) ? HDR : BODY;
                        end
                    end
                end

                HDR: begin
                    if (can_load) begin
                        valid_out <= 1'b1;
                        data_out  <= hdr_sh[SH_WD-1 -: DATA_WD];
                        keep_out  <= '1;
                        last_out  <= 1'b0;
                        hdr_sh    <= hdr_sh << DATA_WD;
                        // Meaningful only after the final full beat: the R leftover bytes.
                        res_dat   <= hdr_sh[SH_WD-DATA_WD-1 -: DATA_WD];
                        hdr_cnt   <= hdr_cnt - LEN_WD'(1);
                        if (hdr_cnt == LEN_WD'(1)) begin
                            state <= BODY;
                        end
                    end
                end

                BODY: begin
                    if (in_hs) begin
                        valid_out <= 1'b1;
                        data_out  <= cat[2*DATA_WD-1 -: DATA_WD];
                        res_dat   <= cat[DATA_WD-1:0];
                        if (!last_in) begin
                            keep_out <= '1;
                            last_out <= 1'b0;
                        end else if (fill <= DATA_BYTE_WD) begin
                            keep_out <= keep_top(fill);
                            last_out <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            // Residual plus last payload overflow one beat: spill into TAIL.
                            keep_out <= '1;
                            last_out <= 1'b0;
                            tail_cnt <= CNT_WD'(fill - DATA_BYTE_WD);
                            state    <= TAIL;
                        end
                    end
                end

                TAIL: begin
                    if (can_load) begin
                        valid_out <= 1'b1;
                        data_out  <= res_dat;
                        keep_out  <= keep_top(int'(tail_cnt));
                        last_out  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_header_insert_multi.sv
// Purpose : self-checking bench for axis_header_insert_multi (DATA_WD=32, HDR_BYTES_MAX=8).
// Latency : expected beats come from a byte-level repacking model pushed into a scoreboard queue.
// Backpr. : ready_out is held high or randomised; a monitor checks held beats while stalled.
module tb_axis_header_insert_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_insert;
    logic [63:0] header_insert;
    logic [3:0]  header_len;
    logic        ready_insert;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] pd[8];
    logic [3:0]  pk[8];
    logic        pl[8];

    logic        stall_prev = 1'b0;
    beat_t       held;
    beat_t       mon_got;
    beat_t       mon_exp;
    logic        rnd_on = 1'b0;

    axis_header_insert_multi dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .keep_in       (keep_in),
        .last_in       (last_in),
        .ready_in      (ready_in),
        .valid_out     (valid_out),
        .data_out      (data_out),
        .keep_out      (keep_out),
        .last_out      (last_out),
        .ready_out     (ready_out),
        .valid_insert  (valid_insert),
        .header_insert (header_insert),
        .header_len    (header_len),
        .ready_insert  (ready_insert)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: compares every transferred beat, and checks held beats under stall.
    always @(negedge clk) begin
        mon_got = {data_out, keep_out, last_out};
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (valid_out !== 1'b1 || mon_got !== held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h",
                             valid_out, mon_got, held);
                end
            end
            if (valid_out === 1'b1 && ready_out === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data=%h keep=%b last=%b, required none",
                             data_out, keep_out, last_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL out_beat: got data=%h keep=%b last=%b, required data=%h keep=%b last=%b",
                                 data_out, keep_out, last_out, mon_exp.d, mon_exp.k, mon_exp.l);
                    end
                end
            end
            stall_prev = (valid_out === 1'b1) && (ready_out !== 1'b1);
            held       = mon_got;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Byte-level reference: header bytes then valid payload bytes, cut into 4-byte beats.
    task automatic expect_pkt(input int len, input logic [63:0] hdr, input int nb);
        logic [7:0]  bq[$];
        logic [31:0] d;
        logic [3:0]  k;
        beat_t       e;
        for (int i = len - 1; i >= 0; i--) bq.push_back(hdr[i*8 +: 8]);
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 4; j++) begin
                if (pk[b][3-j]) bq.push_back(pd[b][31-8*j -: 8]);
            end
        end
        while (bq.size() > 0) begin
            d = '0;
            k = '0;
            for (int j = 0; j < 4; j++) begin
                if (bq.size() > 0) begin
                    d[31-8*j -: 8] = bq.pop_front();
                    k[3-j] = 1'b1;
                end
            end
            e.d = d;
            e.k = k;
            e.l = (bq.size() == 0);
            exp_q.push_back(e);
        end
    endtask

    // All drivers are entered and left just after a rising edge.
    task automatic put_header(input int len, input logic [63:0] hdr);
        int   n;
        logic hs;
        valid_insert  = 1'b1;
        header_len    = 4'(len);
        header_insert = hdr;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = ready_insert;
            @(posedge clk);
            #1;
            n++;
        end
        valid_insert = 1'b0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL header_timeout: got no handshake in %0d cycles, required one", n);
        end
    endtask

    task automatic send_pkt(input int nb);
        int   n;
        logic hs;
        for (int b = 0; b < nb; b++) begin
            valid_in = 1'b1;
            data_in  = pd[b];
            keep_in  = pk[b];
            last_in  = pl[b];
            n  = 0;
            hs = 1'b0;
            while (!hs && n < 200) begin
                @(negedge clk);
                hs = ready_in;
                @(posedge clk);
                #1;
                n++;
            end
            if (!hs) begin
                checks++;
                errors++;
                $display("FAIL payload_timeout: beat %0d got no handshake, required one", b);
            end
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats missing, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic load_t1();
        pd[0] = 32'hAABBCCDD; pk[0] = 4'b1111; pl[0] = 1'b0;
        pd[1] = 32'hEEFF0011; pk[1] = 4'b1111; pl[1] = 1'b0;
        pd[2] = 32'h22334455; pk[2] = 4'b1111; pl[2] = 1'b0;
        pd[3] = 32'h66778899; pk[3] = 4'b1111; pl[3] = 1'b0;
        pd[4] = 32'h00AABBCC; pk[4] = 4'b1100; pl[4] = 1'b1;
    endtask

    task automatic load_t2();
        pd[0] = 32'hAABBCCDD; pk[0] = 4'b1111; pl[0] = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++; if (valid_out !== 1'b0)    begin errors++; $display("FAIL rst_valid_out: got %b required 0", valid_out); end
        checks++; if (last_out !== 1'b0)     begin errors++; $display("FAIL rst_last_out: got %b required 0", last_out); end
        checks++; if (data_out !== 32'h0)    begin errors++; $display("FAIL rst_data_out: got %h required 0", data_out); end
        checks++; if (keep_out !== 4'h0)     begin errors++; $display("FAIL rst_keep_out: got %b required 0", keep_out); end
        checks++; if (ready_in !== 1'b0)     begin errors++; $display("FAIL rst_ready_in: got %b required 0", ready_in); end
        checks++; if (ready_insert !== 1'b0) begin errors++; $display("FAIL rst_ready_insert: got %b required 0", ready_insert); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready_insert !== 1'b0) begin errors++; $display("FAIL post_rst_ready_insert: got %b required 0", ready_insert); end
        checks++; if (valid_out !== 1'b0)    begin errors++; $display("FAIL post_rst_valid_out: got %b required 0", valid_out); end
        @(negedge clk);
        checks++; if (ready_insert !== 1'b1) begin errors++; $display("FAIL idle_ready_insert: got %b required 1", ready_insert); end
        checks++; if (ready_in !== 1'b0)     begin errors++; $display("FAIL idle_ready_in: got %b required 0", ready_in); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hdr3();
        load_t1();
        expect_pkt(3, 64'h12345678_FFEEDDCC, 5);
        put_header(3, 64'h12345678_FFEEDDCC);
        send_pkt(5);
        drain("hdr3");
    endtask

    task automatic test_hdr6();
        load_t2();
        expect_pkt(6, 64'h0000_1122_3344_5566, 1);
        put_header(6, 64'h0000_1122_3344_5566);
        @(negedge clk);
        checks++; if (valid_out !== 1'b1)         begin errors++; $display("FAIL hdr6_latency_valid: got %b required 1", valid_out); end
        checks++; if (data_out !== 32'h11223344)  begin errors++; $display("FAIL hdr6_first_beat: got %h required 11223344", data_out); end
        @(posedge clk);
        #1;
        send_pkt(1);
        drain("hdr6");
    endtask

    task automatic test_bypass();
        pd[0] = 32'h01020304; pk[0] = 4'b1111; pl[0] = 1'b0;
        pd[1] = 32'h05060000; pk[1] = 4'b1100; pl[1] = 1'b1;
        expect_pkt(0, 64'hDEADBEEF_CAFEF00D, 2);
        put_header(0, 64'hDEADBEEF_CAFEF00D);
        valid_in = 1'b1; data_in = pd[0]; keep_in = pk[0]; last_in = pl[0];
        @(negedge clk);
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL bypass_ready_in: got %b required 1", ready_in); end
        @(posedge clk);
        #1;
        data_in = pd[1]; keep_in = pk[1]; last_in = pl[1];
        @(negedge clk);
        checks++; if (valid_out !== 1'b1 || data_out !== 32'h01020304 || keep_out !== 4'b1111)
            begin errors++; $display("FAIL bypass_beat0: got v=%b d=%h k=%b required v=1 d=01020304 k=1111", valid_out, data_out, keep_out); end
        checks++; if (ready_in !== 1'b1) begin errors++; $display("FAIL bypass_ready_in2: got %b required 1", ready_in); end
        @(posedge clk);
        #1;
        valid_in = 1'b0; last_in = 1'b0;
        @(negedge clk);
        checks++; if (valid_out !== 1'b1 || data_out !== 32'h05060000 || keep_out !== 4'b1100 || last_out !== 1'b1)
            begin errors++; $display("FAIL bypass_beat1: got v=%b d=%h k=%b l=%b required v=1 d=05060000 k=1100 l=1", valid_out, data_out, keep_out, last_out); end
        @(posedge clk);
        #1;
        drain("bypass");
    endtask

    task automatic test_payload_first();
        load_t1();
        valid_in = 1'b1; data_in = pd[0]; keep_in = pk[0]; last_in = pl[0];
        repeat (2) begin
            @(negedge clk);
            checks++; if (ready_in !== 1'b0)  begin errors++; $display("FAIL early_ready_in: got %b required 0", ready_in); end
            checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL early_valid_out: got %b required 0", valid_out); end
            @(posedge clk);
            #1;
        end
        expect_pkt(3, 64'h12345678_FFEEDDCC, 5);
        put_header(3, 64'h12345678_FFEEDDCC);
        send_pkt(5);
        drain("early");
    endtask

    task automatic test_back_pressure();
        load_t1();
        expect_pkt(3, 64'h12345678_FFEEDDCC, 5);
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    ready_out = 1'($urandom_range(0, 1));
                end
                ready_out = 1'b1;
            end
        join_none
        put_header(3, 64'h12345678_FFEEDDCC);
        send_pkt(5);
        drain("backpressure");
        rnd_on = 1'b0;
        @(posedge clk);
        #2;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        ready_out = 1'b1;
        load_t1();
        expect_pkt(3, 64'h12345678_FFEEDDCC, 5);
        put_header(3, 64'h12345678_FFEEDDCC);
        send_pkt(2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (valid_out !== 1'b0)    begin errors++; $display("FAIL midrst_valid_out: got %b required 0", valid_out); end
        checks++; if (ready_insert !== 1'b0) begin errors++; $display("FAIL midrst_ready_insert: got %b required 0", ready_insert); end
        checks++; if (ready_in !== 1'b0)     begin errors++; $display("FAIL midrst_ready_in: got %b required 0", ready_in); end
        exp_q.delete();
        @(posedge clk);
        #1;
        load_t2();
        expect_pkt(6, 64'h0000_1122_3344_5566, 1);
        put_header(6, 64'h0000_1122_3344_5566);
        send_pkt(1);
        drain("midrst");
    endtask

    task automatic test_back_to_back();
        ready_out = 1'b1;
        pd[0] = 32'h01020304; pk[0] = 4'b1111; pl[0] = 1'b0;
        pd[1] = 32'h0506ABCD; pk[1] = 4'b1100; pl[1] = 1'b1;
        expect_pkt(8, 64'h88776655_44332211, 2);
        put_header(8, 64'h88776655_44332211);
        send_pkt(2);
        pd[0] = 32'hB1B2B3B4; pk[0] = 4'b1000; pl[0] = 1'b1;
        expect_pkt(4, 64'hFFFFFFFF_A1A2A3A4, 1);
        put_header(4, 64'hFFFFFFFF_A1A2A3A4);
        send_pkt(1);
        pd[0] = 32'hD1D2D3D4; pk[0] = 4'b1110; pl[0] = 1'b1;
        expect_pkt(5, 64'h000000C1_C2C3C4C5, 1);
        put_header(5, 64'h000000C1_C2C3C4C5);
        send_pkt(1);
        drain("b2b");
    endtask

    initial begin
        rst           = 1'b1;
        valid_in      = 1'b0;
        data_in       = '0;
        keep_in       = '0;
        last_in       = 1'b0;
        ready_out     = 1'b1;
        valid_insert  = 1'b0;
        header_insert = '0;
        header_len    = '0;

        test_reset();
        test_hdr3();
        test_hdr6();
        test_bypass();
        test_payload_first();
        test_back_pressure();
        test_reset_mid();
        test_back_to_back();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
